// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage RV32 subset pipeline: load-use stalls,
// multi-cycle mul hold in EX, taken-beq squash of IF/ID, plus debug counters.
module pipeline_sequencer #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs2_i,
  input  logic             id_is_mul_i,
  input  logic             beq_taken_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_bubble_o,
  output logic             mul_busy_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    MUL    = 2'd2,
    UNUSED = 2'd3
  } state_t;

  localparam int MC_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [MC_W-1:0] MUL_INIT = MC_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state, state_n;
  logic [MC_W-1:0] mul_cnt, mul_cnt_n;
  logic            hz;
  logic            mul_start;
  logic            stall_inc;
  logic            flush_inc;

  assign hz = ex_memread_i && (ex_rd_i != 5'd0) &&
              ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
  assign mul_start = id_is_mul_i && (MUL_LAT > 1);
  assign state_o   = state;

  always_comb begin
    state_n        = state;
    mul_cnt_n      = mul_cnt;
    pc_write_o     = 1'b0;
    ifid_write_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_write_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_bubble_o = 1'b0;
    mul_busy_o     = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_n = RUN;
      end
      RUN: begin
        // A hazard wins over everything; a coincident branch re-resolves next cycle.
        if (hz) begin
          idex_write_o  = 1'b1;
          idex_bubble_o = 1'b1;
          stall_inc     = 1'b1;
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          idex_write_o = 1'b1;
          if (mul_start) begin
            state_n   = MUL;
            mul_cnt_n = MUL_INIT;
          end else if (beq_taken_i) begin
            ifid_flush_o = 1'b1;
            flush_inc    = 1'b1;
          end
        end
      end
      MUL: begin
        exmem_bubble_o = 1'b1;
        mul_busy_o     = 1'b1;
        stall_inc      = 1'b1;
        mul_cnt_n      = mul_cnt - 1'b1;
        if (mul_cnt <= MC_W'(1)) state_n = RUN;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      mul_cnt     <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state   <= state_n;
      mul_cnt <= mul_cnt_n;
      if (stall_inc && (stall_cnt_o != CNT_MAX)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_inc && (flush_cnt_o != CNT_MAX)) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Stall/flush sequencer for the 5-stage RV32 subset pipeline (add, sub, mul, and, or, addi, lw, sw, beq).
- Sits beside the decode control unit. Detects load-use hazards, sequences the multi-cycle multiplier in EX, and squashes IF/ID on a taken beq resolved in ID.
- Drives PC, IF/ID and ID/EX write enables, and the bubble inserts.
- Keeps saturating stall and flush counters for debug.

Parameters:
- MUL_LAT, 4: total EX cycles taken by a mul (≥1). A value of 1 means single-cycle, with no hold.
- CNT_W, 16: width of the stall and flush counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-low reset
- start_i  in  1  begin execution; sampled only in IDLE
- id_rs1_i  in  5  rs1 field of the instruction in ID
- id_rs2_i  in  5  rs2 field of the instruction in ID
- id_uses_rs2_i  in  1  ID instruction reads rs2 (R-type, sw, beq)
- id_is_mul_i  in  1  ID instruction is mul
- beq_taken_i  in  1  beq in ID compares equal
- ex_memread_i  in  1  instruction in EX is lw
- ex_rd_i  in  5  rd of the instruction in EX
- pc_write_o  out  1  PC register enable
- ifid_write_o  out  1  IF/ID enable
- ifid_flush_o  out  1  clear IF/ID to nop; also the PC mux select for the branch target
- idex_write_o  out  1  ID/EX enable
- idex_bubble_o  out  1  load nop control into ID/EX
- exmem_bubble_o  out  1  load nop into EX/MEM while mul is held
- mul_busy_o  out  1  high in MUL state
- state_o  out  2  IDLE=0, RUN=1, MUL=2
- stall_cnt_o  out  CNT_W  stall cycles, saturating
- flush_cnt_o  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Clock and reset:
  - Single clock, posedge.
  - When rst_i=0 at an edge: state←IDLE, mul counter←0, stall_cnt←0, flush_cnt←0.
  - Reset overrides everything, including mid-MUL: the hold is abandoned.
- Output timing: all enable/bubble/flush outputs are combinational from the current state and inputs (same-cycle effect on the pipeline registers). Counters and state are registered.
- Load-use hazard (hz): ex_memread_i & ex_rd_i≠0 & (ex_rd_i==id_rs1_i | (id_uses_rs2_i & ex_rd_i==id_rs2_i)).
- IDLE:
  - pc_write=ifid_write=idex_write=0; all bubbles and flush=0.
  - start_i=1 → RUN.
- RUN, priority 1 — hz:
  - pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1, ifid_flush=0.
  - A simultaneous beq_taken_i is ignored; the branch re-resolves next cycle.
  - id_is_mul_i does not start MUL.
- RUN, priority 2 — id_is_mul_i & MUL_LAT>1:
  - Normal advance (all writes=1).
  - Next state MUL, counter←MUL_LAT-1.
- RUN, priority 3 — beq_taken_i:
  - pc_write=1, ifid_write=1, ifid_flush=1, idex_write=1, idex_bubble=0.
  - flush_cnt increments.
- RUN, otherwise: all writes=1, bubbles=0, flush=0.
- MUL:
  - pc_write=ifid_write=idex_write=0, exmem_bubble=1, mul_busy=1.
  - beq_taken_i and hz are ignored; ID and EX are frozen.
  - Counter decrements each cycle. When counter==1, next state is RUN.
  - MUL lasts exactly MUL_LAT-1 cycles.
- stall_cnt:
  - Increments in any non-IDLE cycle with pc_write_o=0 (hz cycles and MUL cycles).
  - Saturates at 2^CNT_W-1; flush_cnt saturates the same way.
- start_i outside IDLE: no effect.
- ex_rd_i=0 (x0): never a hazard.
- Unused state encoding 3: behaves as IDLE and goes to IDLE next cycle.

Test Plan:
- Reset and start:
  - Apply rst_i=0 for 2 cycles → state_o=0, counters 0, pc_write_o=0.
  - Release, pulse start_i → state_o=1 next cycle, pc_write_o=1.
- Load-use:
  - In RUN, ex_memread_i=1, ex_rd_i=5, id_rs2_i=5, id_uses_rs2_i=1 → same cycle pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; stall_cnt_o=1 after the edge.
  - Repeat with ex_rd_i=0 → no stall.
- Taken beq: in RUN, beq_taken_i=1, no hazard → ifid_flush_o=1, pc_write_o=1; flush_cnt_o=1.
- Multiply with MUL_LAT=4:
  - id_is_mul_i=1 for one cycle → state_o=2 for exactly 3 cycles, exmem_bubble_o=1, pc_write_o=0; then RUN.
  - stall_cnt_o=3 at the end.
  - Repeat with MUL_LAT=1 → never enters MUL.
- Simultaneous events:
  - hz=1 with beq_taken_i=1 → ifid_flush_o=0, stall taken.
  - Next cycle, hz=0, beq_taken_i=1 → flush occurs.
  - beq_taken_i=1 during MUL → ignored.
- Reset mid-MUL and saturation:
  - rst_i=0 on the 2nd MUL cycle → IDLE, counters 0.
  - With CNT_W=3, hold hz=1 for 10 cycles → stall_cnt_o sticks at 7.
